// File: rtl/mem_arbiter.sv
// Shares one synchronous-read memory port between instruction fetch and data access.
// Data has fixed priority, but fetch wins after STARVE_MAX consecutive losses; read data returns one cycle after the grant.
module mem_arbiter #(
  parameter int DBITS      = 16,
  parameter int ABITS      = 12,
  parameter int STARVE_MAX = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IREQ,
  input  logic [DBITS-1:0] IADDR,
  output logic             IGNT,
  output logic [DBITS-1:0] IRDATA,
  output logic             IVALID,
  input  logic             DREQ,
  input  logic             DWE,
  input  logic [DBITS-1:0] DADDR,
  input  logic [DBITS-1:0] DWDATA,
  output logic             DGNT,
  output logic [DBITS-1:0] DRDATA,
  output logic             DVALID,
  output logic             DINRANGE,
  output logic [ABITS-1:0] MADDR,
  output logic [DBITS-1:0] MDIN,
  output logic             MWE,
  input  logic [DBITS-1:0] MDOUT
);

  localparam logic [2:0] SMAX = 3'(STARVE_MAX);

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } owner_t;

  owner_t     owner;
  logic       rd;
  logic [2:0] starve_cnt;
  logic       inr;
  logic       fetch_wins;
  logic       unused_addr_bits;

  assign inr        = (DADDR[DBITS-1:ABITS+1] == '0);
  assign fetch_wins = (starve_cnt == SMAX);
  assign unused_addr_bits = ^{IADDR[DBITS-1:ABITS+1], IADDR[0], DADDR[0]};

  // An out-of-range data access never touches memory, so fetch can share its cycle.
  always_comb begin
    IGNT = 1'b0;
    DGNT = 1'b0;
    if (!RST) begin
      if (DREQ && !inr) begin
        DGNT = 1'b1;
        IGNT = IREQ;
      end else if (DREQ && IREQ) begin
        IGNT = fetch_wins;
        DGNT = !fetch_wins;
      end else begin
        DGNT = DREQ;
        IGNT = IREQ;
      end
    end
  end

  assign MADDR = (DGNT && inr) ? DADDR[ABITS:1] : IADDR[ABITS:1];
  assign MWE   = DGNT & DWE & inr;
  assign MDIN  = DWDATA;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      owner      <= OWN_NONE;
      rd         <= 1'b0;
      starve_cnt <= 3'd0;
      DINRANGE   <= 1'b0;
    end else begin
      if (IGNT)
        owner <= OWN_FETCH;
      else if (DGNT && inr)
        owner <= OWN_DATA;
      else
        owner <= OWN_NONE;
      rd <= !DWE;
      if (IGNT)
        starve_cnt <= 3'd0;
      else if (IREQ && starve_cnt != SMAX)
        starve_cnt <= starve_cnt + 3'd1;
      if (DGNT)
        DINRANGE <= inr;
    end
  end

  assign IVALID = !RST && (owner == OWN_FETCH);
  assign DVALID = !RST && (owner == OWN_DATA) && rd;
  assign IRDATA = (owner == OWN_FETCH) ? MDOUT : '0;
  assign DRDATA = (owner == OWN_DATA && rd) ? MDOUT : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model with its own copy of memory.
module tb_mem_arbiter;
  localparam int DBITS = 16;
  localparam int ABITS = 12;
  localparam int SMAX  = 3;

  logic             CLK = 1'b0;
  logic             RST;
  logic             IREQ, DREQ, DWE;
  logic [DBITS-1:0] IADDR, DADDR, DWDATA;
  logic             IGNT, DGNT, IVALID, DVALID, DINRANGE, MWE;
  logic [DBITS-1:0] IRDATA, DRDATA, MDIN, MDOUT;
  logic [ABITS-1:0] MADDR;

  int checks = 0;
  int passed = 0;

  logic [DBITS-1:0] mem     [0:(1<<ABITS)-1];
  logic [DBITS-1:0] ref_mem [0:(1<<ABITS)-1];

  int               m_starve;
  bit               m_vi, m_vd, m_dinr;
  logic [DBITS-1:0] m_ri, m_rd;

  mem_arbiter #(.DBITS(DBITS), .ABITS(ABITS), .STARVE_MAX(SMAX)) dut (
    .CLK(CLK), .RST(RST),
    .IREQ(IREQ), .IADDR(IADDR), .IGNT(IGNT), .IRDATA(IRDATA), .IVALID(IVALID),
    .DREQ(DREQ), .DWE(DWE), .DADDR(DADDR), .DWDATA(DWDATA), .DGNT(DGNT),
    .DRDATA(DRDATA), .DVALID(DVALID), .DINRANGE(DINRANGE),
    .MADDR(MADDR), .MDIN(MDIN), .MWE(MWE), .MDOUT(MDOUT)
  );

  always #5 CLK = ~CLK;

  // Environment memory: synchronous read, write on MWE.
  always @(posedge CLK) begin
    if (MWE) mem[MADDR] <= MDIN;
    MDOUT <= mem[MADDR];
  end

  function automatic bit out_of_range(input logic [DBITS-1:0] a);
    return (a >> (ABITS + 1)) != 0;
  endfunction

  task automatic reset_model();
    m_starve = 0; m_vi = 0; m_vd = 0; m_dinr = 0;
  endtask

  task automatic predict(output bit gi, output bit gd);
    gi = 0; gd = 0;
    if (DREQ && out_of_range(DADDR)) begin
      gd = 1; gi = IREQ;
    end else if (DREQ && IREQ) begin
      gi = (m_starve >= SMAX); gd = !gi;
    end else begin
      gi = IREQ; gd = DREQ;
    end
  endtask

  // Commit one clock of traffic to the model, then advance to just after the edge.
  task automatic step(output bit gi, output bit gd);
    bit oor;
    predict(gi, gd);
    oor  = out_of_range(DADDR);
    m_vi = gi;
    if (gi) m_ri = ref_mem[IADDR[ABITS:1]];
    m_vd = gd && !oor && !DWE;
    if (m_vd) m_rd = ref_mem[DADDR[ABITS:1]];
    if (gd && !oor && DWE) ref_mem[DADDR[ABITS:1]] = DWDATA;
    if (gd) m_dinr = !oor;
    if (IREQ) m_starve = gi ? 0 : ((m_starve < SMAX) ? m_starve + 1 : m_starve);
    @(posedge CLK); #1;
  endtask

  task automatic idle_inputs();
    IREQ = 0; DREQ = 0; DWE = 0; IADDR = '0; DADDR = '0; DWDATA = '0;
  endtask

  task automatic test_reset();
    bit gi, gd;
    RST = 1; idle_inputs();
    repeat (2) @(posedge CLK); #1;
    checks++; if ({IVALID, DVALID, DINRANGE} !== 3'b000) $display("FAIL reset_state got %b want 000", {IVALID, DVALID, DINRANGE}); else passed++;
    RST = 0; reset_model();
    IREQ = 1; DREQ = 1; DWE = 0; DADDR = 16'h0010; IADDR = 16'h0000;
    @(negedge CLK);
    checks++; if ({DGNT, IGNT} !== 2'b10) $display("FAIL pre_reset_grant got %b want 10", {DGNT, IGNT}); else passed++;
    #1 RST = 1;
    #1;
    checks++; if ({IGNT, DGNT, MWE, IVALID, DVALID} !== 5'b0) $display("FAIL reset_forces_zero got %b want 00000", {IGNT, DGNT, MWE, IVALID, DVALID}); else passed++;
    @(posedge CLK); #1;
    checks++; if ({IVALID, DVALID} !== 2'b00) $display("FAIL reset_no_valid got %b want 00", {IVALID, DVALID}); else passed++;
    RST = 0; reset_model();
    @(negedge CLK);
    checks++; if ({DGNT, IGNT} !== 2'b10) $display("FAIL first_grant_after_reset got %b want 10", {DGNT, IGNT}); else passed++;
    step(gi, gd);
    idle_inputs();
  endtask

  task automatic test_fetch_only();
    bit gi, gd;
    IREQ = 1; DREQ = 0; IADDR = 16'h0200;
    @(negedge CLK);
    checks++; if (IGNT !== 1'b1 || MADDR !== 12'h100) $display("FAIL fetch_grant got ignt=%b maddr=%h want 1/100", IGNT, MADDR); else passed++;
    for (int k = 0; k < 3; k++) begin
      step(gi, gd);
      IADDR = 16'h0202 + 16'(2 * k);
      checks++; if (IVALID !== 1'b1 || IRDATA !== m_ri) $display("FAIL fetch_b2b[%0d] got v=%b d=%h want 1/%h", k, IVALID, IRDATA, m_ri); else passed++;
      @(negedge CLK);
      checks++; if (IGNT !== 1'b1 || MADDR !== IADDR[ABITS:1]) $display("FAIL fetch_b2b_grant[%0d] got %b/%h want 1/%h", k, IGNT, MADDR, IADDR[ABITS:1]); else passed++;
    end
    IREQ = 0;
    step(gi, gd);
  endtask

  task automatic test_contention(input int n);
    bit gi, gd, exp_i;
    IREQ = 1; DREQ = 1; DWE = 0; DADDR = 16'h0010; IADDR = 16'h0300;
    for (int k = 0; k < n; k++) begin
      exp_i = (k % 4 == 3);
      @(negedge CLK);
      checks++; if ({IGNT, DGNT} !== {exp_i, !exp_i}) $display("FAIL contention[%0d] got i/d=%b%b want %b%b", k, IGNT, DGNT, exp_i, !exp_i); else passed++;
      checks++; if ({IVALID, DVALID} !== {m_vi, m_vd}) $display("FAIL contention_valid[%0d] got %b%b want %b%b", k, IVALID, DVALID, m_vi, m_vd); else passed++;
      step(gi, gd);
    end
    idle_inputs();
    step(gi, gd);
  endtask

  task automatic test_data_write();
    bit gi, gd;
    DREQ = 1; DWE = 1; DADDR = 16'h0A04; DWDATA = 16'hBEEF;
    @(negedge CLK);
    checks++; if ({DGNT, MWE} !== 2'b11 || MADDR !== 12'h502 || MDIN !== 16'hBEEF) $display("FAIL data_write got g=%b we=%b a=%h d=%h want 1/1/502/beef", DGNT, MWE, MADDR, MDIN); else passed++;
    step(gi, gd);
    idle_inputs();
    checks++; if (DVALID !== 1'b0 || DINRANGE !== 1'b1) $display("FAIL write_after got dvalid=%b dinr=%b want 0/1", DVALID, DINRANGE); else passed++;
    // Read back what was written.
    DREQ = 1; DADDR = 16'h0A04;
    step(gi, gd);
    idle_inputs();
    checks++; if (DVALID !== 1'b1 || DRDATA !== 16'hBEEF) $display("FAIL write_readback got v=%b d=%h want 1/beef", DVALID, DRDATA); else passed++;
  endtask

  task automatic test_out_of_range();
    bit gi, gd;
    DREQ = 1; DWE = 1; DADDR = 16'hFFFC; IREQ = 1; IADDR = 16'h0400;
    @(negedge CLK);
    checks++; if ({DGNT, IGNT, MWE} !== 3'b110 || MADDR !== 12'h200) $display("FAIL oor_grant got d/i/we=%b%b%b a=%h want 110/200", DGNT, IGNT, MWE, MADDR); else passed++;
    step(gi, gd);
    idle_inputs();
    checks++; if ({DINRANGE, DVALID, IVALID} !== 3'b001 || IRDATA !== m_ri) $display("FAIL oor_after got dinr/dv/iv=%b%b%b d=%h want 001/%h", DINRANGE, DVALID, IVALID, IRDATA, m_ri); else passed++;
  endtask

  task automatic test_reset_during_read();
    bit gi, gd;
    IREQ = 1; DREQ = 1; DWE = 0; DADDR = 16'h0020; IADDR = 16'h0600;
    step(gi, gd);
    @(negedge CLK);
    checks++; if (DGNT !== 1'b1) $display("FAIL rdr_grant got %b want 1", DGNT); else passed++;
    #2 RST = 1;
    @(posedge CLK); #1;
    checks++; if ({DVALID, IVALID} !== 2'b00) $display("FAIL rdr_dropped got %b want 00", {DVALID, IVALID}); else passed++;
    RST = 0; reset_model();
    // Starvation counter restarts at zero: three data wins before fetch.
    test_contention(4);
  endtask

  task automatic test_random(input int n);
    bit gi, gd, ipend, dpend;
    ipend = 0; dpend = 0;
    for (int k = 0; k < n; k++) begin
      if (!ipend) begin
        IREQ  = ($urandom_range(2) != 0);
        IADDR = 16'($urandom);
        ipend = IREQ;
      end
      if (!dpend) begin
        DREQ   = ($urandom_range(2) != 0);
        DWE    = 1'($urandom);
        DWDATA = 16'($urandom);
        DADDR  = ($urandom_range(4) == 0) ? (16'($urandom) | 16'h8000) : (16'($urandom) & 16'h1FFF);
        dpend  = DREQ;
      end
      @(negedge CLK);
      predict(gi, gd);
      checks++; if ({IGNT, DGNT} !== {gi, gd}) $display("FAIL rand_grant[%0d] got %b%b want %b%b", k, IGNT, DGNT, gi, gd); else passed++;
      if (gd && !out_of_range(DADDR)) begin
        checks++; if (MADDR !== DADDR[ABITS:1] || MWE !== DWE) $display("FAIL rand_daddr[%0d] got %h/%b want %h/%b", k, MADDR, MWE, DADDR[ABITS:1], DWE); else passed++;
      end else if (gi) begin
        checks++; if (MADDR !== IADDR[ABITS:1] || MWE !== 1'b0) $display("FAIL rand_iaddr[%0d] got %h/%b want %h/0", k, MADDR, MWE, IADDR[ABITS:1]); else passed++;
      end
      checks++; if ({IVALID, DVALID, DINRANGE} !== {m_vi, m_vd, m_dinr}) $display("FAIL rand_flags[%0d] got %b%b%b want %b%b%b", k, IVALID, DVALID, DINRANGE, m_vi, m_vd, m_dinr); else passed++;
      if (m_vi) begin
        checks++; if (IRDATA !== m_ri) $display("FAIL rand_irdata[%0d] got %h want %h", k, IRDATA, m_ri); else passed++;
      end
      if (m_vd) begin
        checks++; if (DRDATA !== m_rd) $display("FAIL rand_drdata[%0d] got %h want %h", k, DRDATA, m_rd); else passed++;
      end
      step(gi, gd);
      if (gi) ipend = 0;
      if (gd) dpend = 0;
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < (1 << ABITS); i++) begin
      mem[i]     = 16'(i * 37 + 5) ^ 16'h5A00;
      ref_mem[i] = 16'(i * 37 + 5) ^ 16'h5A00;
    end
    MDOUT = '0;
    reset_model();
    test_reset();
    test_fetch_only();
    test_contention(8);
    test_data_write();
    test_out_of_range();
    test_reset_during_read();
    test_random(400);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
